// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the front-panel button debouncer.
// Channel indices follow the stopwatch panel wiring.
package debounce_pkg;

    localparam int DB_CLK_DIV      = 100;
    localparam int DB_STABLE_CNT   = 5;
    localparam int DB_REPEAT_FIRST = 50;
    localparam int DB_REPEAT_RATE  = 10;

    localparam int CH_RST    = 0;
    localparam int CH_PAUSE  = 1;
    localparam int CH_ADJ    = 2;
    localparam int CH_SELECT = 3;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        if (result < 32'sd1) begin
            result = 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced button: synchroniser, stability counter, edge pulses and
// an optional hold-to-repeat timer, all advanced by a shared sample tick.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT   = DB_STABLE_CNT,
    parameter int REPEAT_FIRST = DB_REPEAT_FIRST,
    parameter int REPEAT_RATE  = DB_REPEAT_RATE,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_tick,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int SW = clog2(STABLE_CNT + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);

    logic          sync_a_r;
    logic          sync_b_r;
    logic [SW-1:0] stab_cnt_r;
    logic          flip_s;

    // The level flips on the tick that supplies the last required differing sample.
    assign flip_s = sample_tick && (sync_b_r != btn_level) && (stab_cnt_r == STABLE_LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_r <= 1'b0;
            sync_b_r <= 1'b0;
        end else begin
            sync_a_r <= btn_in;
            sync_b_r <= sync_a_r;
        end
    end

    // Stability counter, debounced level and one-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_cnt_r  <= {SW{1'b0}};
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (flip_s) begin
                stab_cnt_r  <= {SW{1'b0}};
                btn_level   <= ~btn_level;
                btn_press   <= ~btn_level;
                btn_release <= btn_level;
            end else if (sample_tick) begin
                if (sync_b_r == btn_level) begin
                    stab_cnt_r <= {SW{1'b0}};
                end else begin
                    stab_cnt_r <= stab_cnt_r + SW'(1);
                end
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int HW = clog2(REPEAT_FIRST + 1);
            localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_FIRST - 1);
            localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_FIRST - REPEAT_RATE);

            logic [HW-1:0] hold_cnt_r;

            // Reloading below the threshold keeps the timer bounded during long holds.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_cnt_r <= {HW{1'b0}};
                    btn_repeat <= 1'b0;
                end else begin
                    btn_repeat <= 1'b0;
                    if (!btn_level || flip_s) begin
                        hold_cnt_r <= {HW{1'b0}};
                    end else if (sample_tick) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            hold_cnt_r <= HOLD_RELOAD;
                            btn_repeat <= 1'b1;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HW'(1);
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
            end
        end else begin : g_no_repeat
            assign btn_repeat = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: one shared sample prescaler feeding
// an independent debounce channel per button.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                NUM_CH       = 4,
    parameter int                CLK_DIV      = DB_CLK_DIV,
    parameter int                STABLE_CNT   = DB_STABLE_CNT,
    parameter int                REPEAT_FIRST = DB_REPEAT_FIRST,
    parameter int                REPEAT_RATE  = DB_REPEAT_RATE,
    parameter logic [NUM_CH-1:0] REPEAT_MASK  = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_repeat,
    output logic              sample_tick
);

    localparam int DW = clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

    logic [DW-1:0] div_cnt_r;

    // Prescaler; the tick is registered one count early so it lines up with the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r   <= {DW{1'b0}};
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (div_cnt_r == DIV_PRE);
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= {DW{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            debounce_chan #(
                .STABLE_CNT   (STABLE_CNT),
                .REPEAT_FIRST (REPEAT_FIRST),
                .REPEAT_RATE  (REPEAT_RATE),
                .REPEAT_EN    (REPEAT_MASK[i])
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .sample_tick (sample_tick),
                .btn_in      (btn_in[i]),
                .btn_level   (btn_level[i]),
                .btn_press   (btn_press[i]),
                .btn_release (btn_release[i]),
                .btn_repeat  (btn_repeat[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: a window-based reference model predicts
// every pulse, a monitor pops and compares them as the DUT emits them.
module tb_debounce_bank;

    localparam int NC  = 4;
    localparam int DIV = 4;
    localparam int SC  = 3;
    localparam int RF  = 6;
    localparam int RR  = 2;
    localparam logic [NC-1:0] RMASK = 4'b0100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] btn_in = '0;
    logic [NC-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic          sample_tick;

    debounce_bank #(
        .NUM_CH(NC), .CLK_DIV(DIV), .STABLE_CNT(SC),
        .REPEAT_FIRST(RF), .REPEAT_RATE(RR), .REPEAT_MASK(RMASK)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 press, 1 release, 2 repeat
    } ev_t;

    ev_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [NC-1:0] mdl_level = '0;
    logic          mdl_tick = 1'b0;
    int            press_cnt[NC];
    int            rel_cnt[NC];
    int            rep_cnt[NC];

    // Reference model state
    logic [NC-1:0] h1 = '0, h2 = '0;
    int            k = 0;
    int            held[NC];
    int            nsamp[NC];
    bit            win[NC][SC];

    // Reference model: level flips when the last SC tick samples all disagree with it.
    initial begin : model
        bit s;
        bit settled;
        for (int c = 0; c < NC; c++) begin
            held[c] = 0; nsamp[c] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                k = 0; h1 = '0; h2 = '0; mdl_level = '0; mdl_tick = 1'b0;
                for (int c = 0; c < NC; c++) begin
                    held[c] = 0; nsamp[c] = 0;
                end
            end else begin
                k++;
                if (k % DIV == 0) begin
                    for (int c = 0; c < NC; c++) begin
                        s = h2[c];
                        for (int j = SC - 1; j > 0; j--) win[c][j] = win[c][j-1];
                        win[c][0] = s;
                        nsamp[c]++;
                        settled = (nsamp[c] >= SC);
                        for (int j = 0; j < SC; j++) if (win[c][j] == mdl_level[c]) settled = 1'b0;
                        if (settled) begin
                            mdl_level[c] = ~mdl_level[c];
                            held[c] = 0;
                            exp_q.push_back('{cyc, c, (mdl_level[c] ? 0 : 1)});
                        end else if (mdl_level[c]) begin
                            held[c]++;
                            if (RMASK[c] && held[c] >= RF && ((held[c] - RF) % RR) == 0)
                                exp_q.push_back('{cyc, c, 2});
                        end
                    end
                end
                mdl_tick = (k % DIV == DIV - 1);
                h2 = h1;
                h1 = btn_in;
            end
        end
    end

    // Monitor: compares level and tick every cycle, pops the scoreboard on every pulse.
    initial begin : monitor
        ev_t  e;
        logic p;
        for (int c = 0; c < NC; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; rep_cnt[c] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (btn_level !== mdl_level) begin
                errors++;
                $display("FAIL level @cyc %0d: got %b expected %b", cyc, btn_level, mdl_level);
            end
            checks++;
            if (sample_tick !== mdl_tick) begin
                errors++;
                $display("FAIL sample_tick @cyc %0d: got %b expected %b", cyc, sample_tick, mdl_tick);
            end
            for (int c = 0; c < NC; c++) begin
                for (int kd = 0; kd < 3; kd++) begin
                    p = (kd == 0) ? btn_press[c] : ((kd == 1) ? btn_release[c] : btn_repeat[c]);
                    if (p === 1'b1) begin
                        if (kd == 0) press_cnt[c]++;
                        if (kd == 1) rel_cnt[c]++;
                        if (kd == 2) rep_cnt[c]++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL pulse @cyc %0d: got ch%0d kind %0d, expected no pulse", cyc, c, kd);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.ch != c || e.kind != kd) begin
                                errors++;
                                $display("FAIL pulse: got cyc %0d ch%0d kind %0d, expected cyc %0d ch%0d kind %0d",
                                         cyc, c, kd, e.cyc, e.ch, e.kind);
                            end
                        end
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing pulse: got none, expected cyc %0d ch%0d kind %0d", e.cyc, e.ch, e.kind);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = n * DIV * 2 + 20;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (sample_tick === 1'b1) seen++;
            budget--;
        end
        check("tick_budget", seen, n);
    endtask

    task automatic wait_model_level(input int c);
        int budget;
        budget = 100;
        while (!mdl_level[c] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("model_level_wait", int'(mdl_level[c]), 1);
    endtask

    initial begin : stim
        int n;
        int base_a;
        int base_b;
        int bit_i;

        // Reset with all buttons pressed
        rst = 1'b1;
        btn_in = 4'hF;
        repeat (3) @(negedge clk);
        check("level_in_reset", int'(btn_level), 0);
        rst = 1'b0;
        wait_ticks(3);
        check("level_before_3rd_tick", int'(btn_level), 0);
        @(posedge clk); @(negedge clk);
        check("level_after_3rd_tick", int'(btn_level), 15);

        // Release everything
        btn_in = 4'h0;
        wait_ticks(4);
        check("all_released", int'(btn_level), 0);

        // Clean press on ch1 with latency bound
        base_a = press_cnt[1];
        btn_in[1] = 1'b1;
        n = 0;
        while (btn_level[1] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ch1_latency_in_range", int'(n >= 10 && n <= 14), 1);
        wait_ticks(1);
        check("ch1_press_count", press_cnt[1] - base_a, 1);
        check("ch1_only_level", int'(btn_level), 2);

        // Bounce rejection on ch0: 1,1,0,1,1,1 on successive ticks
        base_a = press_cnt[0];
        wait_ticks(1);
        for (int j = 0; j < 6; j++) begin
            btn_in[0] = (j == 2) ? 1'b0 : 1'b1;
            wait_ticks(1);
        end
        check("ch0_no_early_press", press_cnt[0] - base_a, 0);
        check("ch0_no_early_level", int'(btn_level[0]), 0);
        @(posedge clk); @(negedge clk);
        check("ch0_press_after_bounce", press_cnt[0] - base_a, 1);

        // Release on ch3
        btn_in[3] = 1'b1;
        wait_ticks(5);
        base_a = rel_cnt[3];
        base_b = press_cnt[3];
        btn_in[3] = 1'b0;
        wait_ticks(4);
        check("ch3_release_count", rel_cnt[3] - base_a, 1);
        check("ch3_no_press", press_cnt[3] - base_b, 0);

        // Auto-repeat: ch2 masked in, ch0 masked out
        btn_in = 4'h0;
        wait_ticks(5);
        btn_in = 4'b0101;
        wait_model_level(2);
        base_a = rep_cnt[2];
        base_b = rep_cnt[0];
        wait_ticks(20);
        @(posedge clk); @(negedge clk);
        check("ch2_repeat_count", rep_cnt[2] - base_a, 8);
        check("ch0_repeat_count", rep_cnt[0] - base_b, 0);

        // Reset while ch2 is held
        btn_in = 4'h0;
        wait_ticks(5);
        btn_in[2] = 1'b1;
        wait_model_level(2);
        wait_ticks(5);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ch2_level_after_rst", int'(btn_level[2]), 0);
        base_a = press_cnt[2];
        base_b = rep_cnt[2];
        wait_ticks(3);
        @(posedge clk); @(negedge clk);
        check("ch2_repress_count", press_cnt[2] - base_a, 1);
        wait_ticks(6);
        check("ch2_no_repeat_before_6", rep_cnt[2] - base_b, 0);
        @(posedge clk); @(negedge clk);
        check("ch2_repeat_at_6", rep_cnt[2] - base_b, 1);

        // Random bouncing traffic
        for (int j = 0; j < 800; j++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                bit_i = $urandom_range(0, NC - 1);
                btn_in[bit_i] = ~btn_in[bit_i];
            end
        end
        btn_in = 4'($urandom_range(0, 15));
        wait_ticks(5);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
